// File: rtl/compound_accum_pkg.sv
// Types and accumulator limits for compound_accum.
package compound_accum_types;
    import testbasic16_types::*;

    typedef enum logic {section_recv = 1'b0, section_send = 1'b1} Sections;

    localparam logic [DATA_W-1:0] ACC_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] ACC_MIN = {1'b1, {(DATA_W-1){1'b0}}};
endpackage

// File: rtl/testbasic16_types.sv
// Packet types shared with the upstream TestBasic16 stage.
package testbasic16_types;
    localparam int DATA_W = 32;

    typedef enum logic {read = 1'b0, write = 1'b1} Mode;

    typedef struct packed {
        Mode               mode;
        logic [DATA_W-1:0] x;
        logic              y;
    } CompoundType;
endpackage

// File: rtl/compound_accum_alu.sv
// Accumulator update: load or signed add with overflow flag.
// COMPOUND_ACCUM_SAT_EN selects saturating adds instead of wrapping.
module compound_accum_alu
    import compound_accum_types::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_acc,
    input  logic [DATA_W-1:0] i_x,
    input  logic              i_load,
    output logic [DATA_W-1:0] o_sum,
    output logic              o_ovf_bit
);
    logic [DATA_W-1:0] w_add;
    logic              w_ovf;

    assign w_add = i_acc + i_x;
    // Signed overflow: operands agree in sign but the result does not.
    assign w_ovf = (i_acc[DATA_W-1] == i_x[DATA_W-1]) && (w_add[DATA_W-1] != i_acc[DATA_W-1]);

    always_comb begin
        o_sum     = w_add;
        o_ovf_bit = 1'b0;
        if (i_load) begin
            o_sum = i_x;
        end else begin
            o_ovf_bit = w_ovf;
`ifdef COMPOUND_ACCUM_SAT_EN
            if (w_ovf) o_sum = i_acc[DATA_W-1] ? ACC_MIN : ACC_MAX;
`else
            o_sum = w_add;
`endif
        end
    end
endmodule

// File: rtl/compound_accum.sv
// Packet-driven accumulator: writes add/load, reads return {read, acc, ovf}.
// Optional saturating adds via COMPOUND_ACCUM_SAT_EN (see compound_accum_alu).
module compound_accum
    import testbasic16_types::*;
    import compound_accum_types::*;
#(
    parameter int DATA_W     = 32,
    parameter int AUTO_FLUSH = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  CompoundType b_in,
    input  logic        b_in_sync,
    output logic        b_in_notify,
    output CompoundType b_out,
    input  logic        b_out_sync,
    output logic        b_out_notify
);
    localparam int CNT_W = (AUTO_FLUSH > 0) ? $clog2(AUTO_FLUSH + 1) : 1;

    Sections           r_section, w_section_nx;
    logic [DATA_W-1:0] r_acc;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_wcnt;
    CompoundType       r_out;

    logic              w_in_xfer, w_out_xfer, w_is_write, w_flush, w_new_ovf, w_ovf_bit;
    logic [DATA_W-1:0] w_sum;
    logic [CNT_W-1:0]  w_wcnt_inc;

    assign w_in_xfer  = b_in_notify && b_in_sync;
    assign w_out_xfer = b_out_notify && b_out_sync;
    assign w_is_write = (b_in.mode == write);
    assign w_wcnt_inc = r_wcnt + 1'b1;
    assign w_new_ovf  = b_in.y ? 1'b0 : (r_ovf | w_ovf_bit);
    assign w_flush    = (AUTO_FLUSH > 0) && (w_wcnt_inc == CNT_W'(AUTO_FLUSH));

    compound_accum_alu #(.DATA_W(DATA_W)) u_alu (
        .i_acc     (r_acc),
        .i_x       (b_in.x),
        .i_load    (b_in.y),
        .o_sum     (w_sum),
        .o_ovf_bit (w_ovf_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_section <= section_recv;
        else      r_section <= w_section_nx;
    end

    always_comb begin
        w_section_nx = r_section;
        case (r_section)
            section_recv: if (w_in_xfer && (!w_is_write || w_flush)) w_section_nx = section_send;
            section_send: if (w_out_xfer) w_section_nx = section_recv;
            default:      w_section_nx = section_recv;
        endcase
    end

    always_comb begin
        b_in_notify  = (r_section == section_recv);
        b_out_notify = (r_section == section_send);
    end

    // Notify gates the transfer, so the datapath only moves in section_recv.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_wcnt <= '0;
            r_out  <= '{read, {DATA_W{1'b0}}, 1'b0};
        end else if (w_in_xfer) begin
            if (w_is_write) begin
                r_acc <= w_sum;
                r_ovf <= w_new_ovf;
                if (w_flush) begin
                    r_wcnt <= '0;
                    r_out  <= '{write, w_sum, w_new_ovf};
                end else begin
                    r_wcnt <= w_wcnt_inc;
                end
            end else begin
                r_out  <= '{read, r_acc, r_ovf};
                r_wcnt <= '0;
                if (b_in.y) begin
                    r_acc <= '0;
                    r_ovf <= 1'b0;
                end
            end
        end
    end

    assign b_out = r_out;
endmodule

// File: tb/tb_compound_accum.sv
// Bench for compound_accum: two instances (AUTO_FLUSH 0 and 3), directed + random.
module tb_compound_accum;
    import testbasic16_types::*;

    logic        clk = 1'b0;
    logic        rst;
    CompoundType in_pkt[2];
    CompoundType out_pkt[2];
    logic        in_sync[2], in_ntf[2], out_sync[2], out_ntf[2];
    int          tests = 0;
    int          fails = 0;
    bit          cmp_en = 1'b0;

    logic [31:0] m_acc[2];
    logic        m_ovf[2];
    int          m_wcnt[2];
    bit          m_send[2];
    CompoundType m_out[2];

    always #5 clk = ~clk;

    compound_accum #(.DATA_W(32), .AUTO_FLUSH(0)) u_dut0 (
        .clk(clk), .rst(rst), .b_in(in_pkt[0]), .b_in_sync(in_sync[0]), .b_in_notify(in_ntf[0]),
        .b_out(out_pkt[0]), .b_out_sync(out_sync[0]), .b_out_notify(out_ntf[0]));

    compound_accum #(.DATA_W(32), .AUTO_FLUSH(3)) u_dut1 (
        .clk(clk), .rst(rst), .b_in(in_pkt[1]), .b_in_sync(in_sync[1]), .b_in_notify(in_ntf[1]),
        .b_out(out_pkt[1]), .b_out_sync(out_sync[1]), .b_out_notify(out_ntf[1]));

    function automatic CompoundType mk(Mode m, logic [31:0] x, logic y);
        CompoundType p;
        p.mode = m;
        p.x    = x;
        p.y    = y;
        return p;
    endfunction

    function automatic int af(int k);
        return (k == 1) ? 3 : 0;
    endfunction

    // Reference arithmetic done in 64-bit signed integers.
    function automatic logic [31:0] model_sum(logic [31:0] a, logic [31:0] x);
        longint s = longint'($signed(a)) + longint'($signed(x));
`ifdef COMPOUND_ACCUM_SAT_EN
        if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    function automatic logic model_ovf(logic [31:0] a, logic [31:0] x);
        longint s = longint'($signed(a)) + longint'($signed(x));
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    function automatic logic [31:0] nacc(int k);
        return in_pkt[k].y ? in_pkt[k].x : model_sum(m_acc[k], in_pkt[k].x);
    endfunction

    function automatic logic novf(int k);
        return in_pkt[k].y ? 1'b0 : (m_ovf[k] | model_ovf(m_acc[k], in_pkt[k].x));
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                m_acc[k]  <= '0;
                m_ovf[k]  <= 1'b0;
                m_wcnt[k] <= 0;
                m_send[k] <= 1'b0;
                m_out[k]  <= mk(read, 32'd0, 1'b0);
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!m_send[k]) begin
                    if (in_sync[k]) begin
                        if (in_pkt[k].mode == write) begin
                            m_acc[k] <= nacc(k);
                            m_ovf[k] <= novf(k);
                            if (af(k) > 0 && m_wcnt[k] + 1 == af(k)) begin
                                m_wcnt[k] <= 0;
                                m_out[k]  <= mk(write, nacc(k), novf(k));
                                m_send[k] <= 1'b1;
                            end else begin
                                m_wcnt[k] <= m_wcnt[k] + 1;
                            end
                        end else begin
                            m_out[k]  <= mk(read, m_acc[k], m_ovf[k]);
                            m_wcnt[k] <= 0;
                            m_send[k] <= 1'b1;
                            if (in_pkt[k].y) begin
                                m_acc[k] <= '0;
                                m_ovf[k] <= 1'b0;
                            end
                        end
                    end
                end else if (out_sync[k]) begin
                    m_send[k] <= 1'b0;
                end
            end
        end
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkp(input string nm, input CompoundType act, input CompoundType exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got {%0d,%h,%b} expected {%0d,%h,%b} at %0t",
                     nm, act.mode, act.x, act.y, exp.mode, exp.x, exp.y, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst && cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                chk1($sformatf("dut%0d in_notify", k), in_ntf[k], !m_send[k]);
                chk1($sformatf("dut%0d out_notify", k), out_ntf[k], m_send[k]);
                chkp($sformatf("dut%0d b_out", k), out_pkt[k], m_out[k]);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic put(input int k, input Mode md, input logic [31:0] x, input logic y);
        int n = 0;
        in_pkt[k]  = mk(md, x, y);
        in_sync[k] = 1'b1;
        while (!in_ntf[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            tests++;
            fails++;
            $display("FAIL put timeout dut%0d: b_in_notify stayed %b, required 1", k, in_ntf[k]);
        end
        @(negedge clk);
        in_sync[k] = 1'b0;
    endtask

    task automatic get(input int k, input CompoundType exp, input string nm);
        int n = 0;
        while (!out_ntf[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk1({nm, " out_notify"}, out_ntf[k], 1'b1);
        chkp({nm, " dut"}, out_pkt[k], exp);
        chkp({nm, " model"}, m_out[k], exp);
        out_sync[k] = 1'b1;
        @(negedge clk);
        out_sync[k] = 1'b0;
        chk1({nm, " in_notify back"}, in_ntf[k], 1'b1);
    endtask

    initial begin
        CompoundType snap;
        for (int k = 0; k < 2; k++) begin
            in_pkt[k]   = mk(read, 32'd0, 1'b0);
            in_sync[k]  = 1'b0;
            out_sync[k] = 1'b0;
        end
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk1("reset in_notify", in_ntf[k], 1'b1);
            chk1("reset out_notify", out_ntf[k], 1'b0);
            chkp("reset b_out", out_pkt[k], mk(read, 32'd0, 1'b0));
        end
        rst    = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // accumulate and read
        put(0, write, 32'd5, 1'b0);
        put(0, write, 32'd7, 1'b0);
        put(0, read, 32'd0, 1'b0);
        get(0, mk(read, 32'd12, 1'b0), "t1 read12");

        // read-and-clear returns the pre-clear snapshot
        put(0, read, 32'd0, 1'b1);
        get(0, mk(read, 32'd12, 1'b0), "t3 clear read");
        put(0, read, 32'd0, 1'b0);
        get(0, mk(read, 32'd0, 1'b0), "t3 after clear");

        // positive overflow boundary
        put(0, write, 32'h7FFF_FFFF, 1'b1);
        put(0, write, 32'd1, 1'b0);
        put(0, read, 32'd0, 1'b1);
`ifdef COMPOUND_ACCUM_SAT_EN
        get(0, mk(read, 32'h7FFF_FFFF, 1'b1), "t2 sat");
`else
        get(0, mk(read, 32'h8000_0000, 1'b1), "t2 wrap");
`endif

        // back-pressure on b_out
        put(0, write, 32'd3, 1'b0);
        put(0, read, 32'd0, 1'b0);
        snap = out_pkt[0];
        repeat (5) begin
            @(negedge clk);
            chkp("t4 hold b_out", out_pkt[0], snap);
            chk1("t4 hold in_notify", in_ntf[0], 1'b0);
        end
        get(0, mk(read, 32'd3, 1'b0), "t4 release");

        // reset while a result is pending
        put(0, write, 32'd9, 1'b0);
        put(0, read, 32'd0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk1("t6 out_notify", out_ntf[0], 1'b0);
        chkp("t6 b_out", out_pkt[0], mk(read, 32'd0, 1'b0));
        rst = 1'b1;
        @(negedge clk);
        put(0, read, 32'd0, 1'b0);
        get(0, mk(read, 32'd0, 1'b0), "t6 read0");

        // auto flush after three writes
        put(1, write, 32'd1, 1'b0);
        put(1, write, 32'd2, 1'b0);
        put(1, write, 32'd3, 1'b0);
        get(1, mk(write, 32'd6, 1'b0), "t5 flush");
        put(1, write, 32'd4, 1'b0);
        put(1, read, 32'd0, 1'b0);
        get(1, mk(read, 32'd10, 1'b0), "t5 read10");

        // random traffic, checked every cycle against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                logic [31:0] x;
                x = ($urandom_range(0, 3) == 0) ? (32'h7FFF_FFF0 + 32'($urandom_range(0, 31)))
                                                : 32'($urandom);
                in_pkt[k]   = mk(Mode'($urandom_range(0, 1)), x, ($urandom_range(0, 3) == 0));
                in_sync[k]  = ($urandom_range(0, 3) != 0);
                out_sync[k] = ($urandom_range(0, 2) != 0);
            end
            rst = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_sync[k]  = 1'b0;
            out_sync[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
